// File: rtl/pfpu_vwriter_pkg.sv
// Shared definitions for the PFPU vertex writer: FSM encoding, WISHBONE burst
// tags and the mesh-to-address mapping.
package pfpu_vwriter_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_BEAT0,
      S_BEAT1,
      S_DONE
   } state_t;

   localparam logic [2:0] CTI_INCR = 3'b010;
   localparam logic [2:0] CTI_END  = 3'b111;

   localparam int MESH_W    = 7;
   localparam int VTX_SHIFT = 3;
   localparam int ROW_SHIFT = MESH_W + VTX_SHIFT;
   localparam int BASE_LSB  = ROW_SHIFT + MESH_W;
   localparam int CNT_W     = 2*MESH_W + 1;

   // Rows are a fixed 128 vertices apart regardless of mesh width.
   function automatic logic [31:0] beat_addr(input logic [31-BASE_LSB:0] base,
                                             input logic [MESH_W-1:0] r1,
                                             input logic [MESH_W-1:0] r0,
                                             input logic second);
      return {base, r1, r0, second, 2'b00};
   endfunction

endpackage

// File: rtl/pfpu_vwriter_fifo.sv
// First-word-fall-through vertex FIFO; the head entry is visible on dout
// whenever empty is low.
module pfpu_vwriter_fifo #(
   parameter int DEPTH_LOG2 = 2,
   parameter int W          = 64
) (
   input  logic         sys_clk,
   input  logic         sys_rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   logic [W-1:0]        mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
   logic                wr_en, rd_en;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
   end

endmodule

// File: rtl/pfpu_vwriter.sv
// Writes PFPU vertex results to memory as two-beat WISHBONE bursts, walking
// the mesh r0-fastest and flagging done after the last vertex lands.
module pfpu_vwriter
   import pfpu_vwriter_pkg::*;
#(
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        start,
   input  logic [31:0] dma_base,
   input  logic [6:0]  hmesh_last,
   input  logic [6:0]  vmesh_last,
   input  logic        vtx_stb,
   input  logic [31:0] vtx_x,
   input  logic [31:0] vtx_y,
   output logic        vtx_ack,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   output logic [2:0]  wbm_cti_o,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   input  logic        wbm_ack_i,
   output logic        busy,
   output logic        done
);

   state_t                 state, state_nxt;
   logic [31-BASE_LSB:0]   base;
   logic [MESH_W-1:0]      hlast, vlast, r0, r1;
   logic [CNT_W-1:0]       acc_cnt, total;
   logic [31:0]            cur_x, cur_y;
   logic [63:0]            fifo_dout;
   logic                   fifo_full, fifo_empty, push, pop, last;
   logic                   unused_base;

   assign unused_base = ^dma_base[BASE_LSB-1:0];

   assign busy    = (state == S_FETCH) || (state == S_BEAT0) || (state == S_BEAT1);
   assign done    = (state == S_DONE);
   assign vtx_ack = busy && !fifo_full && (acc_cnt != total);
   assign push    = vtx_stb && vtx_ack;
   assign pop     = (state == S_FETCH) && !fifo_empty;
   assign last    = (r0 == hlast) && (r1 == vlast);

   pfpu_vwriter_fifo #(
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
      .W          (64)
   ) u_fifo (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .push    (push),
      .din     ({vtx_y, vtx_x}),
      .pop     (pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_FETCH;
         S_FETCH: if (!fifo_empty) state_nxt = S_BEAT0;
         S_BEAT0: if (wbm_ack_i) state_nxt = S_BEAT1;
         S_BEAT1: if (wbm_ack_i) state_nxt = last ? S_DONE : S_FETCH;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state   <= S_IDLE;
         r0      <= '0;
         r1      <= '0;
         acc_cnt <= '0;
         total   <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && start) begin
            r0      <= '0;
            r1      <= '0;
            acc_cnt <= '0;
            total   <= (CNT_W'(hmesh_last) + 1'b1) * (CNT_W'(vmesh_last) + 1'b1);
         end else if (push) begin
            acc_cnt <= acc_cnt + 1'b1;
         end
         if (state == S_BEAT1 && wbm_ack_i && !last) begin
            if (r0 == hlast) begin
               r0 <= '0;
               r1 <= r1 + 1'b1;
            end else begin
               r0 <= r0 + 1'b1;
            end
         end
      end
   end

   // Pass configuration and the in-flight vertex need no reset.
   always_ff @(posedge sys_clk) begin
      if (state == S_IDLE && start) begin
         base  <= dma_base[31:BASE_LSB];
         hlast <= hmesh_last;
         vlast <= vmesh_last;
      end
      if (pop) {cur_y, cur_x} <= fifo_dout;
   end

   assign wbm_cyc_o = (state == S_BEAT0) || (state == S_BEAT1);
   assign wbm_stb_o = wbm_cyc_o;
   assign wbm_we_o  = wbm_cyc_o;
   assign wbm_sel_o = 4'hf;
   assign wbm_cti_o = (state == S_BEAT1) ? CTI_END : CTI_INCR;
   assign wbm_dat_o = (state == S_BEAT1) ? cur_y : cur_x;
   assign wbm_adr_o = beat_addr(base, r1, r0, state == S_BEAT1);

endmodule

// File: tb/tb_pfpu_vwriter.sv
// Scoreboard bench for pfpu_vwriter: stimulus queues expected bus beats,
// a monitor pops and checks them as the slave acknowledges.
module tb_pfpu_vwriter;
   import pfpu_vwriter_pkg::*;

   logic        sys_clk, sys_rst, start;
   logic [31:0] dma_base;
   logic [6:0]  hmesh_last, vmesh_last;
   logic        vtx_stb, vtx_ack;
   logic [31:0] vtx_x, vtx_y;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic [2:0]  wbm_cti_o;
   logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;
   logic        busy, done;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [2:0]  cti;
   } beat_t;

   beat_t       sq[$];
   logic [63:0] vq[$];
   int          n_cmp = 0, n_bad = 0;
   int          done_cnt = 0, acc_total = 0, ncyc = 0;
   int          done_neg = -10, end_neg = -10;
   logic        ack_en = 1'b0;
   logic        prev_done = 1'b0;

   assign wbm_ack_i = ack_en & wbm_cyc_o & wbm_stb_o;

   pfpu_vwriter #(.FIFO_DEPTH_LOG2(2)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .start      (start),
      .dma_base   (dma_base),
      .hmesh_last (hmesh_last),
      .vmesh_last (vmesh_last),
      .vtx_stb    (vtx_stb),
      .vtx_x      (vtx_x),
      .vtx_y      (vtx_y),
      .vtx_ack    (vtx_ack),
      .wbm_adr_o  (wbm_adr_o),
      .wbm_dat_o  (wbm_dat_o),
      .wbm_sel_o  (wbm_sel_o),
      .wbm_cti_o  (wbm_cti_o),
      .wbm_we_o   (wbm_we_o),
      .wbm_cyc_o  (wbm_cyc_o),
      .wbm_stb_o  (wbm_stb_o),
      .wbm_ack_i  (wbm_ack_i),
      .busy       (busy),
      .done       (done)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic add_vtx(input logic [31:0] x, input logic [31:0] y, input logic [31:0] adr);
      vq.push_back({y, x});
      sq.push_back(beat_t'{adr, x, CTI_INCR});
      sq.push_back(beat_t'{adr + 32'd4, y, CTI_END});
   endtask

   task automatic do_start(input logic [31:0] b, input logic [6:0] h, input logic [6:0] v);
      dma_base   = b;
      hmesh_last = h;
      vmesh_last = v;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_pass(input string name, input int prev);
      int t = 0;
      while (done_cnt == prev && t < 3000) begin
         tick();
         t++;
      end
      if (done_cnt == prev) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: no done pulse within %0d cycles", name, t);
      end
      tick(3);
      chk({name, "_done_count"}, done_cnt, prev + 1);
      chk({name, "_sb_empty"}, sq.size(), 0);
      chk({name, "_busy_after"}, {31'b0, busy}, 0);
   endtask

   // Vertex source: presents the queue head, retires it once accepted.
   initial begin
      logic xfer;
      vtx_stb = 1'b0;
      vtx_x   = '0;
      vtx_y   = '0;
      forever begin
         @(negedge sys_clk);
         xfer = vtx_stb & vtx_ack;
         @(posedge sys_clk);
         #1;
         if (xfer && vq.size() > 0) begin
            void'(vq.pop_front());
            acc_total++;
         end
         if (vq.size() > 0) begin
            vtx_stb = 1'b1;
            {vtx_y, vtx_x} = vq[0];
         end else begin
            vtx_stb = 1'b0;
         end
      end
   end

   // Bus monitor: each acknowledged beat must match the scoreboard head.
   initial begin
      beat_t e;
      forever begin
         @(negedge sys_clk);
         ncyc++;
         if (!sys_rst && wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
            if (sq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_beat: adr 0x%08h dat 0x%08h with nothing expected",
                        wbm_adr_o, wbm_dat_o);
            end else begin
               e = sq.pop_front();
               chk("beat_adr", wbm_adr_o, e.adr);
               chk("beat_dat", wbm_dat_o, e.dat);
               chk("beat_cti", {29'b0, wbm_cti_o}, {29'b0, e.cti});
               chk("beat_sel", {28'b0, wbm_sel_o}, 32'hf);
               chk("beat_we", {31'b0, wbm_we_o}, 32'd1);
               if (wbm_cti_o == CTI_END) end_neg = ncyc;
            end
         end
         if (done) begin
            done_cnt++;
            done_neg = ncyc;
            chk("done_single_cycle", {31'b0, prev_done}, 0);
            chk("busy_low_at_done", {31'b0, busy}, 0);
         end
         prev_done = done;
      end
   end

   initial begin
      int   prev, a0, t;
      logic [31:0] cap_adr, cap_dat;
      logic stable;

      sys_rst    = 1'b1;
      start      = 1'b0;
      dma_base   = '0;
      hmesh_last = '0;
      vmesh_last = '0;
      ack_en     = 1'b1;
      tick(3);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_vtx_ack", {31'b0, vtx_ack}, 0);
      chk("rst_cyc", {31'b0, wbm_cyc_o}, 0);
      chk("rst_stb", {31'b0, wbm_stb_o}, 0);
      sys_rst = 1'b0;
      tick(2);

      // 2x2 mesh, free-running slave
      add_vtx(32'h0, 32'h100, 32'h4002_0000);
      add_vtx(32'h1, 32'h101, 32'h4002_0008);
      add_vtx(32'h2, 32'h102, 32'h4002_0400);
      add_vtx(32'h3, 32'h103, 32'h4002_0408);
      tick(2);
      chk("idle_no_accept", acc_total, 0);
      prev = done_cnt;
      a0 = acc_total;
      do_start(32'h4002_0000, 7'd1, 7'd1);
      chk("t1_busy", {31'b0, busy}, 1);
      wait_pass("t1", prev);
      chk("t1_accepted", acc_total - a0, 4);

      // Backpressure: beat 0 stalled for 20 cycles on a 4x2 mesh
      ack_en = 1'b0;
      for (int i = 0; i < 8; i++)
         add_vtx(32'h200 + i, 32'h300 + i,
                 32'h8000_0000 + ((i / 4) << 10) + ((i % 4) << 3));
      prev = done_cnt;
      do_start(32'h8000_0000, 7'd3, 7'd1);
      tick(12);
      chk("t2_fifo_full_ack", {31'b0, vtx_ack}, 0);
      chk("t2_pending_vtx", vq.size(), 3);
      chk("t2_stb", {31'b0, wbm_stb_o}, 1);
      cap_adr = wbm_adr_o;
      cap_dat = wbm_dat_o;
      chk("t2_stall_adr", cap_adr, 32'h8000_0000);
      chk("t2_stall_dat", cap_dat, 32'h200);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (wbm_adr_o !== cap_adr || wbm_dat_o !== cap_dat || wbm_stb_o !== 1'b1 ||
             wbm_cti_o !== CTI_INCR || vtx_ack !== 1'b0)
            stable = 1'b0;
      end
      chk("t2_stall_stable", {31'b0, stable}, 1);
      ack_en = 1'b1;
      wait_pass("t2", prev);

      // Over-supply: 3x3 mesh fed 10 vertices
      for (int i = 0; i < 9; i++)
         add_vtx(32'h400 + i, 32'h500 + i,
                 32'h0004_0000 + ((i / 3) << 10) + ((i % 3) << 3));
      vq.push_back({32'hDEAD, 32'hBEEF});
      prev = done_cnt;
      a0 = acc_total;
      do_start(32'h0004_0000, 7'd2, 7'd2);
      wait_pass("t3", prev);
      tick(10);
      chk("t3_accepted", acc_total - a0, 9);
      chk("t3_surplus_left", vq.size(), 1);
      chk("t3_idle_ack", {31'b0, vtx_ack}, 0);
      vq.delete();
      tick(2);

      // 1x1 mesh; low base bits must be dropped
      add_vtx(32'hCAFE_0001, 32'hCAFE_0002, 32'h1234_0000);
      prev = done_cnt;
      do_start(32'h1235_5678, 7'd0, 7'd0);
      wait_pass("t4", prev);
      chk("t4_done_latency", done_neg - end_neg, 1);

      // Reset while the third vertex's second beat is waiting
      for (int i = 0; i < 4; i++)
         add_vtx(32'h600 + i, 32'h700 + i, 32'h0006_0000 + (i << 3));
      prev = done_cnt;
      do_start(32'h0006_0000, 7'd3, 7'd3);
      t = 0;
      while (!(wbm_cyc_o && wbm_cti_o == CTI_END && wbm_adr_o == 32'h0006_0014) && t < 500) begin
         tick();
         t++;
      end
      chk("t5_reached_beat1", {31'b0, wbm_cyc_o}, 1);
      ack_en  = 1'b0;
      sys_rst = 1'b1;
      tick();
      chk("t5_cyc_after_rst", {31'b0, wbm_cyc_o}, 0);
      chk("t5_stb_after_rst", {31'b0, wbm_stb_o}, 0);
      chk("t5_busy_after_rst", {31'b0, busy}, 0);
      sys_rst = 1'b0;
      ack_en  = 1'b1;
      chk("t5_pending_beats", sq.size(), 3);
      chk("t5_all_vtx_taken", vq.size(), 0);
      sq.delete();
      tick(5);
      chk("t5_no_done", done_cnt, prev);
      add_vtx(32'hA0, 32'hB0, 32'h0006_0000);
      add_vtx(32'hA1, 32'hB1, 32'h0006_0008);
      do_start(32'h0006_0000, 7'd1, 7'd0);
      wait_pass("t5b", prev);

      // start while busy must not disturb the running pass
      add_vtx(32'h800, 32'h900, 32'h2000_0000);
      add_vtx(32'h801, 32'h901, 32'h2000_0008);
      add_vtx(32'h802, 32'h902, 32'h2000_0400);
      add_vtx(32'h803, 32'h903, 32'h2000_0408);
      prev = done_cnt;
      a0 = acc_total;
      do_start(32'h2000_0000, 7'd1, 7'd1);
      tick();
      chk("t6_busy", {31'b0, busy}, 1);
      dma_base   = 32'hFFFE_0000;
      hmesh_last = 7'd5;
      vmesh_last = 7'd5;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      wait_pass("t6", prev);
      chk("t6_accepted", acc_total - a0, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
